// File: rtl/axis_weight_packer_if.sv
// Bus bundle for axis_weight_packer: descriptor channel, row input stream
// and packed output stream. The "slave" modport is the packer's view;
// "master" is the view of whatever drives the packer.
interface axis_weight_packer_if #(
  parameter int CFG_W   = 36,
  parameter int M_WIDTH = 32,
  parameter int S_WIDTH = 128,
  parameter int KEEP_W  = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CFG_W-1:0]   cfg_data;

  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic [M_WIDTH-1:0] s_axis_tdata;
  logic               s_axis_tlast;

  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [S_WIDTH-1:0] m_axis_tdata;
  logic [KEEP_W-1:0]  m_axis_tkeep;
  logic               m_axis_tlast;

  modport slave (
    input  cfg_valid, cfg_data,
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
    input  m_axis_tready,
    output cfg_ready, s_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  modport master (
    output cfg_valid, cfg_data,
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
    output m_axis_tready,
    input  cfg_ready, s_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );
endinterface

// File: rtl/axis_weight_packer.sv
// Packs PE weight rows R-per-beat into the weight-rotator packet format:
// a descriptor header beat, then addr_max+1 rows, tlast on the last beat.
// Length mismatches between the descriptor and the row stream raise a
// sticky err_len; surplus rows are drained and dropped.
`ifndef COLS
`define COLS 4
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif
`ifndef S_WEIGHTS_WIDTH_LF
`define S_WEIGHTS_WIDTH_LF 128
`endif
`ifndef CONFIG_BEATS
`define CONFIG_BEATS 2
`endif

module axis_weight_packer #(
  parameter int COLS               = `COLS,
  parameter int WORD_WIDTH         = `WORD_WIDTH,
  parameter int S_WEIGHTS_WIDTH_LF = `S_WEIGHTS_WIDTH_LF,
  parameter int CONFIG_BEATS       = `CONFIG_BEATS,
  parameter int BRAM_WEIGHTS_DEPTH = 1024,
  parameter int KW_MAX             = 11,
  parameter int CI_MAX             = 512,
  parameter int XW_MAX             = 32,
  parameter int XH_MAX             = 32,
  parameter int XN_MAX             = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_weight_packer_if.slave   bus,
  output logic                  err_len
);
  localparam int M_WIDTH     = WORD_WIDTH * COLS;
  localparam int S_W         = S_WEIGHTS_WIDTH_LF;
  localparam int R           = S_W / M_WIDTH;
  localparam int KEEP_W      = S_W / WORD_WIDTH;
  localparam int BITS_ADDR   = $clog2(BRAM_WEIGHTS_DEPTH);
  localparam int BITS_KW2    = $clog2((KW_MAX + 1) / 2);
  localparam int BITS_CIN    = $clog2(CI_MAX);
  localparam int BITS_COLS   = $clog2(XW_MAX);
  localparam int BITS_BLOCKS = $clog2(XH_MAX);
  localparam int BITS_XN     = $clog2(XN_MAX);
  localparam int CFG_W       = BITS_ADDR + BITS_XN + BITS_BLOCKS + BITS_COLS + BITS_CIN + BITS_KW2;
  localparam int LANE_W      = (R > 1) ? $clog2(R) : 1;
  localparam bit PARAMS_OK   = ((S_W % M_WIDTH) == 0) && (CFG_W <= S_W) && (CONFIG_BEATS >= 0);

  // A bad parameter set leaves this marker block in the elaborated hierarchy.
  if (!PARAMS_OK) begin : g_params_invalid
  end

  typedef enum logic [1:0] {IDLE, HEAD, PACK, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [BITS_ADDR-1:0] addr_max_q, addr_max_d;
  logic [BITS_ADDR-1:0] row_q, row_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [S_W-1:0]       acc_data_q, acc_data_d;
  logic [KEEP_W-1:0]    acc_keep_q, acc_keep_d;
  logic [S_W-1:0]       m_data_q, m_data_d;
  logic [KEEP_W-1:0]    m_keep_q, m_keep_d;
  logic                 m_last_q, m_last_d;
  logic                 m_valid_q, m_valid_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 err_q, err_d;

  logic                 s_ready;
  logic                 m_hs;
  logic                 row_final;
  logic                 lane_full;
  logic [S_W-1:0]       data_v;
  logic [KEEP_W-1:0]    keep_v;

  assign bus.cfg_ready     = cfg_ready_q;
  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tvalid = m_valid_q;
  assign bus.m_axis_tdata  = m_data_q;
  assign bus.m_axis_tkeep  = m_keep_q;
  assign bus.m_axis_tlast  = m_last_q;
  assign err_len           = err_q;

  // Next-state, row packing and output-register loading.
  always_comb begin
    state_d    = state_q;
    addr_max_d = addr_max_q;
    row_d      = row_q;
    lane_d     = lane_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q;
    err_d      = err_q;
    s_ready    = 1'b0;
    data_v     = acc_data_q;
    keep_v     = acc_keep_q;

    m_hs      = m_valid_q && bus.m_axis_tready;
    row_final = (row_q == addr_max_q) || bus.s_axis_tlast;
    lane_full = (lane_q == LANE_W'(R - 1));

    // A consumed beat drops valid unless something below reloads it.
    if (m_hs) m_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_ready_q && bus.cfg_valid) begin
          addr_max_d = bus.cfg_data[CFG_W-1 -: BITS_ADDR];
          row_d      = '0;
          lane_d     = '0;
          acc_data_d = '0;
          acc_keep_d = '0;
          m_data_d   = S_W'(bus.cfg_data);
          m_keep_d   = '1;
          m_last_d   = 1'b0;
          m_valid_d  = 1'b1;
          state_d    = HEAD;
        end
      end
      HEAD: begin
        if (m_hs) state_d = PACK;
      end
      PACK: begin
        // Only take a row when the output register is free this edge.
        s_ready = !m_valid_q || bus.m_axis_tready;
        if (s_ready && bus.s_axis_tvalid) begin
          data_v[int'(lane_q)*M_WIDTH +: M_WIDTH] = bus.s_axis_tdata;
          keep_v[int'(lane_q)*COLS +: COLS]       = '1;
          if (lane_full || row_final) begin
            m_data_d   = data_v;
            m_keep_d   = keep_v;
            m_last_d   = row_final;
            m_valid_d  = 1'b1;
            acc_data_d = '0;
            acc_keep_d = '0;
            lane_d     = '0;
          end else begin
            acc_data_d = data_v;
            acc_keep_d = keep_v;
            lane_d     = lane_q + LANE_W'(1);
          end
          if (row_final) begin
            if (bus.s_axis_tlast) begin
              if (row_q != addr_max_q) err_d = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else begin
            row_d = row_q + BITS_ADDR'(1);
          end
        end
      end
      DRAIN: begin
        s_ready = 1'b1;
        if (bus.s_axis_tvalid && bus.s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Hold off the next descriptor until the last beat has left.
    cfg_ready_d = (state_d == IDLE) && !m_valid_d;
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      addr_max_q  <= '0;
      row_q       <= '0;
      lane_q      <= '0;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_max_q  <= addr_max_d;
      row_q       <= row_d;
      lane_q      <= lane_d;
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
      cfg_ready_q <= cfg_ready_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_axis_weight_packer.sv
// Bench for axis_weight_packer: table of packets (normal, partial, stalled,
// single-row, length errors) plus async-reset sequence; expected beats are
// queued as stimulus is accepted and checked when the DUT emits them.
module tb_axis_weight_packer;
  localparam int CFG_W  = 36;
  localparam int M_W    = 32;
  localparam int S_W    = 128;
  localparam int KEEP_W = 16;

  typedef struct packed {
    logic [S_W-1:0]    data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  typedef struct {
    int addr_max;
    int n_rows;
    int tlast_row;
    bit bp;
    int exp_beats;
  } vec_t;

  logic clk;
  logic rst_n;
  logic err_len;

  axis_weight_packer_if #(.CFG_W(CFG_W), .M_WIDTH(M_W), .S_WIDTH(S_W), .KEEP_W(KEEP_W)) bus ();

  axis_weight_packer #(
    .COLS(4), .WORD_WIDTH(8), .S_WEIGHTS_WIDTH_LF(128), .CONFIG_BEATS(2),
    .BRAM_WEIGHTS_DEPTH(1024), .KW_MAX(11), .CI_MAX(512),
    .XW_MAX(32), .XH_MAX(32), .XN_MAX(16)
  ) dut (
    .aclk(clk),
    .aresetn(rst_n),
    .bus(bus),
    .err_len(err_len)
  );

  int    tests = 0;
  int    fails = 0;
  int    beats_seen = 0;
  beat_t sb[$];

  // Reference model state.
  logic [S_W-1:0]    mdl_data;
  logic [KEEP_W-1:0] mdl_keep;
  int                mdl_lane;
  bit                mdl_ended;
  int                mdl_addr_max;
  bit                exp_err = 1'b0;
  bit                in_pack = 1'b0;

  bit bp_mode = 1'b0;
  bit bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int bp_cnt = 0;

  bit    stall_prev = 1'b0;
  beat_t held;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [S_W-1:0] got, input logic [S_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for DUT, got no handshake expected one", name);
  endtask

  // Downstream ready: always 1, or the 1,0,0,1 pattern when backpressure is on.
  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_axis_tready = bp_mode ? bp_pat[bp_cnt % 4] : 1'b1;
      bp_cnt++;
    end
  end

  // Output monitor: scoreboard compare on handshake, stability while stalled.
  always @(negedge clk) begin
    beat_t got;
    beat_t exp;
    got = {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast};
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        tests++;
        if (!(bus.m_axis_tvalid === 1'b1 && got === held)) begin
          fails++;
          $display("FAIL stall_stable: got valid=%b beat=%h expected valid=1 beat=%h",
                   bus.m_axis_tvalid, got, held);
        end
      end
      if (bus.m_axis_tvalid && !bus.m_axis_tready) begin
        if (in_pack) begin
          tests++;
          if (bus.s_axis_tready !== 1'b0) begin
            fails++;
            $display("FAIL s_ready_stall: got %b expected 0", bus.s_axis_tready);
          end
        end
        stall_prev = 1'b1;
        held = got;
      end else begin
        stall_prev = 1'b0;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        tests++;
        beats_seen++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got %h expected no beat", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL beat: got data=%h keep=%h last=%b expected data=%h keep=%h last=%b",
                     got.data, got.keep, got.last, exp.data, exp.keep, exp.last);
          end else begin
            $display("[TB] beat data=%h keep=%h last=%b", got.data, got.keep, got.last);
          end
        end
      end
    end
  end

  task automatic send_cfg(input int addr_max);
    logic [CFG_W-1:0] c;
    beat_t b;
    bit ok;
    c = '0;
    c[25:0] = 26'($urandom);
    c[35:26] = 10'(addr_max);
    bus.cfg_data  = c;
    bus.cfg_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.cfg_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout_fail("cfg_handshake");
      bus.cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    b.data = S_W'(c);
    b.keep = '1;
    b.last = 1'b0;
    sb.push_back(b);
    chk("header_latency", S_W'(bus.m_axis_tvalid), S_W'(1));
    mdl_data     = '0;
    mdl_keep     = '0;
    mdl_lane     = 0;
    mdl_ended    = 1'b0;
    mdl_addr_max = addr_max;
    in_pack      = 1'b1;
  endtask

  // Drive one row and wait for its accepting edge; returns 0 on timeout.
  task automatic drive_row(input logic [M_W-1:0] d, input bit last, output bit ok);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = last;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      timeout_fail("row_handshake");
    end
  endtask

  // Model: place an accepted row and queue the beat it completes.
  task automatic accept_row(input int k, input logic [M_W-1:0] d, input bit last);
    beat_t b;
    bit fin;
    if (!mdl_ended) begin
      mdl_data[mdl_lane*M_W +: M_W] = d;
      mdl_keep[mdl_lane*4 +: 4]     = 4'hF;
      fin = (k == mdl_addr_max) || last;
      if (mdl_lane == 3 || fin) begin
        b.data = mdl_data;
        b.keep = mdl_keep;
        b.last = fin;
        sb.push_back(b);
        mdl_data = '0;
        mdl_keep = '0;
        mdl_lane = 0;
      end else begin
        mdl_lane++;
      end
      if (fin) begin
        mdl_ended = 1'b1;
        in_pack   = 1'b0;
        if (k != mdl_addr_max || !last) exp_err = 1'b1;
      end
    end
  endtask

  task automatic wait_drained(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) timeout_fail(name);
  endtask

  task automatic run_packet(input int idx, input vec_t v);
    logic [M_W-1:0] d;
    bit ok;
    bp_mode    = v.bp;
    beats_seen = 0;
    send_cfg(v.addr_max);
    for (int k = 0; k < v.n_rows; k++) begin
      d = $urandom;
      drive_row(d, (k == v.tlast_row), ok);
      if (!ok) break;
      accept_row(k, d, (k == v.tlast_row));
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    wait_drained("packet_drain");
    repeat (3) @(posedge clk);
    #1;
    chk("beat_count", S_W'(beats_seen), S_W'(v.exp_beats));
    chk("err_len", S_W'(err_len), S_W'(exp_err));
    $display("[TB] packet %0d addr_max=%0d rows=%0d beats=%0d err_len=%b",
             idx, v.addr_max, v.n_rows, beats_seen, err_len);
  endtask

  vec_t vecs[7];

  initial begin
    logic [M_W-1:0] d;
    bit ok;
    vec_t v;

    vecs[0] = '{addr_max: 7,  n_rows: 8,  tlast_row: 7,  bp: 1'b0, exp_beats: 3}; // normal
    vecs[1] = '{addr_max: 5,  n_rows: 6,  tlast_row: 5,  bp: 1'b0, exp_beats: 3}; // partial last beat
    vecs[2] = '{addr_max: 7,  n_rows: 8,  tlast_row: 7,  bp: 1'b1, exp_beats: 3}; // backpressure
    vecs[3] = '{addr_max: 0,  n_rows: 1,  tlast_row: 0,  bp: 1'b0, exp_beats: 2}; // single row
    vecs[4] = '{addr_max: 12, n_rows: 13, tlast_row: 12, bp: 1'b1, exp_beats: 5}; // longer, stalled
    vecs[5] = '{addr_max: 7,  n_rows: 3,  tlast_row: 2,  bp: 1'b0, exp_beats: 2}; // early tlast
    vecs[6] = '{addr_max: 7,  n_rows: 11, tlast_row: 10, bp: 1'b1, exp_beats: 3}; // missing tlast

    rst_n             = 1'b0;
    bus.cfg_valid     = 1'b0;
    bus.cfg_data      = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;

    // Reset values while held in reset across an edge.
    #12;
    chk("rst_m_valid", S_W'(bus.m_axis_tvalid), S_W'(0));
    chk("rst_m_tdata", bus.m_axis_tdata, S_W'(0));
    chk("rst_m_tkeep", S_W'(bus.m_axis_tkeep), S_W'(0));
    chk("rst_m_tlast", S_W'(bus.m_axis_tlast), S_W'(0));
    chk("rst_s_ready", S_W'(bus.s_axis_tready), S_W'(0));
    chk("rst_cfg_ready", S_W'(bus.cfg_ready), S_W'(0));
    chk("rst_err_len", S_W'(err_len), S_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cfg_ready_before_edge", S_W'(bus.cfg_ready), S_W'(0));
    @(posedge clk);
    #1;
    chk("cfg_ready_after_release", S_W'(bus.cfg_ready), S_W'(1));

    for (int i = 0; i < 7; i++) begin
      run_packet(i, vecs[i]);
    end

    // Asynchronous reset mid-packet, between clock edges.
    bp_mode = 1'b0;
    send_cfg(7);
    for (int k = 0; k < 5; k++) begin
      d = $urandom;
      drive_row(d, 1'b0, ok);
      if (!ok) break;
      accept_row(k, d, 1'b0);
    end
    bus.s_axis_tvalid = 1'b0;
    wait_drained("pre_reset_drain");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    in_pack = 1'b0;
    exp_err = 1'b0;
    chk("async_m_valid", S_W'(bus.m_axis_tvalid), S_W'(0));
    chk("async_m_tdata", bus.m_axis_tdata, S_W'(0));
    chk("async_m_tkeep", S_W'(bus.m_axis_tkeep), S_W'(0));
    chk("async_m_tlast", S_W'(bus.m_axis_tlast), S_W'(0));
    chk("async_s_ready", S_W'(bus.s_axis_tready), S_W'(0));
    chk("async_cfg_ready", S_W'(bus.cfg_ready), S_W'(0));
    chk("async_err_len", S_W'(err_len), S_W'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("cfg_ready_after_async", S_W'(bus.cfg_ready), S_W'(1));
    beats_seen = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_partial_after_reset", S_W'(beats_seen), S_W'(0));

    v = '{addr_max: 3, n_rows: 4, tlast_row: 3, bp: 1'b0, exp_beats: 2};
    run_packet(7, v);
    chk("scoreboard_empty", S_W'(sb.size()), S_W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
